// File: rtl/ram_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_controller
// Description : Request sequencer for the 64 x 32-bit latch RAM. It accepts
//               byte-addressed read/write requests over valid/ready and drives
//               registered address/data/is_write strobes. Every write uses a
//               setup/pulse/hold sequence, and partial byte-mask writes use a
//               read-modify-write. Read data is returned with a one-cycle
//               response strobe.
//               Optional macro RAM_CTRL_ZERO_INIT_EN: zero-fill all 64 words
//               after reset before accepting requests.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_access_controller #(
    parameter int unsigned PULSE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_bmask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [7:0]  ram_address,
    output logic [31:0] ram_in,
    output logic        ram_is_write,
    input  logic [31:0] ram_out
);

`ifdef RAM_CTRL_ZERO_INIT_EN
    localparam logic c_zero_init = 1'b1;
`else
    localparam logic c_zero_init = 1'b0;
`endif

    localparam logic [3:0] c_pulse_last = 4'(PULSE_CYCLES - 1);
    localparam logic [7:0] c_last_word  = 8'd63;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RMW_RD   = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_pulse_cnt;
    logic [31:0] r_wdata;
    logic [3:0]  r_bmask;
    logic        r_init;
    logic        w_accept;
    logic        w_resp_next;
    logic [31:0] w_merge;

    assign w_accept = req_valid && req_ready;

    // Next-state decode, read-modify-write lane merge and response decision
    always_comb begin
        w_state_next = r_state;
        w_merge      = ram_out;
        w_resp_next  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_bmask[i]) begin
                w_merge[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!req_write) begin
                        w_state_next = RD_WAIT;
                    end else if (req_bmask == 4'hF) begin
                        w_state_next = WR_SETUP;
                    end else if (req_bmask == 4'h0) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = RMW_RD;
                    end
                end
            end
            RD_WAIT:  w_state_next = IDLE;
            RMW_RD:   w_state_next = WR_SETUP;
            WR_SETUP: w_state_next = WR_PULSE;
            WR_PULSE: begin
                if (r_pulse_cnt == c_pulse_last) begin
                    w_state_next = WR_HOLD;
                end
            end
            WR_HOLD: begin
                // The zero-fill sweep loops back to setup until word 63 is done
                if (r_init && (ram_address != c_last_word)) begin
                    w_state_next = WR_SETUP;
                end else begin
                    w_state_next = IDLE;
                end
            end
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
        // Sweep completion is not a request completion, so it gets no response
        if (w_state_next == IDLE) begin
            w_resp_next = (r_state == RD_WAIT) || (r_state == DONE) ||
                          ((r_state == WR_HOLD) && !r_init);
        end
    end

    // State register plus all registered outputs and the captured request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_zero_init ? WR_SETUP : IDLE;
            r_init       <= c_zero_init;
            req_ready    <= !c_zero_init;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            ram_address  <= 8'h0;
            ram_in       <= 32'h0;
            ram_is_write <= 1'b0;
            r_pulse_cnt  <= 4'h0;
            r_wdata      <= 32'h0;
            r_bmask      <= 4'h0;
        end else begin
            r_state      <= w_state_next;
            req_ready    <= (w_state_next == IDLE);
            resp_valid   <= w_resp_next;
            ram_is_write <= (w_state_next == WR_PULSE);
            r_pulse_cnt  <= (r_state == WR_PULSE) ? r_pulse_cnt + 4'd1 : 4'd0;

            if ((r_state == IDLE) && w_accept) begin
                // Byte address to word index; bits [1:0] shift out
                ram_address <= req_addr >> 2;
                r_wdata     <= req_wdata;
                r_bmask     <= req_bmask;
                if (req_write && (req_bmask == 4'hF)) begin
                    ram_in <= req_wdata;
                end
            end

            if (r_state == RD_WAIT) begin
                resp_rdata <= ram_out;
            end

            if (r_state == RMW_RD) begin
                ram_in <= w_merge;
            end

            // Advance the sweep only after the hold cycle of the previous word
            if ((r_state == WR_HOLD) && r_init) begin
                if (w_state_next == IDLE) begin
                    r_init <= 1'b0;
                end else begin
                    ram_address <= ram_address + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_controller
// Description : Self-checking bench for ram_access_controller with a
//               behavioural latch-RAM model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_controller;

    localparam int P = 4;
`ifdef RAM_CTRL_ZERO_INIT_EN
    localparam int   SWEEP     = 64 * (P + 2);
    localparam logic READY_RST = 1'b0;
`else
    localparam int   SWEEP     = 0;
    localparam logic READY_RST = 1'b1;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_bmask;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [7:0]  ram_address;
    logic [31:0] ram_in;
    logic        ram_is_write;
    logic [31:0] ram_out;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_mem[64];
    logic [31:0] last_rdata;
    logic        preload;
    logic        rst_at_edge;
    logic        prev_we;
    logic [7:0]  prev_addr;
    logic [31:0] prev_in;
    logic [31:0] ram_mem[256];

    ram_access_controller #(.PULSE_CYCLES(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_bmask    (req_bmask),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .ram_address  (ram_address),
        .ram_in       (ram_in),
        .ram_is_write (ram_is_write),
        .ram_out      (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Behavioural RAM: combinational read, write while strobe is high
    assign ram_out = ram_mem[ram_address];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= pat(i);
        end else if (ram_is_write) begin
            ram_mem[ram_address] <= ram_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response scoreboard and strobe-stability monitor
    always @(posedge clk) rst_at_edge <= reset;
    always @(negedge clk) begin
        if (rst_at_edge === 1'b0) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) chk("resp_unexpected", 32'(resp_valid), 32'd0);
                else                   chk("resp_rdata", resp_rdata, exp_q.pop_front());
            end
            if (ram_is_write || prev_we)
                chk("strobe_stable", 32'((ram_address != prev_addr) || (ram_in != prev_in)), 32'd0);
        end
        prev_we   <= ram_is_write;
        prev_addr <= ram_address;
        prev_in   <= ram_in;
    end

    task automatic do_reset(input int cycles);
        int n;
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'(READY_RST));
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        chk("rst_ram_in", ram_in, 32'd0);
        chk("rst_ram_is_write", 32'(ram_is_write), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        last_rdata = 32'h0;
        n = 0;
        while (!req_ready && n < SWEEP + 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_delay", 32'(n), 32'(SWEEP));
`ifdef RAM_CTRL_ZERO_INIT_EN
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
`endif
    endtask

    // One request: starts and ends on a falling edge
    task automatic do_req(input logic wr, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [3:0] bm);
        int exp_lat, exp_pul, lat, pul, badaddr;
        logic [5:0]  w;
        logic [31:0] nw;
        w  = addr[7:2];
        nw = exp_mem[w];
        if (!wr) begin
            exp_lat = 1; exp_pul = 0; last_rdata = exp_mem[w];
        end else if (bm == 4'hF) begin
            exp_lat = P + 2; exp_pul = P; exp_mem[w] = wd;
        end else if (bm == 4'h0) begin
            exp_lat = 1; exp_pul = 0;
        end else begin
            exp_lat = P + 3; exp_pul = P;
            for (int i = 0; i < 4; i++) if (bm[i]) nw[8*i +: 8] = wd[8*i +: 8];
            exp_mem[w] = nw;
        end
        exp_q.push_back(last_rdata);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_bmask = bm;
        chk($sformatf("ready_%h", addr), 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; pul = 0; badaddr = 0;
        forever begin
            if (ram_is_write) begin
                pul++;
                if (ram_address !== {2'b00, w}) badaddr++;
            end
            if (resp_valid || lat >= 100) break;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency_%s_%h", wr ? "wr" : "rd", addr), 32'(lat), 32'(exp_lat));
        chk($sformatf("pulses_%h", addr), 32'(pul), 32'(exp_pul));
        chk($sformatf("pulse_addr_%h", addr), 32'(badaddr), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h0; req_wdata = 32'h0; req_bmask = 4'h0;
        last_rdata = 32'h0;
        for (int i = 0; i < 64; i++) exp_mem[i] = pat(i);
        @(negedge clk);
        preload = 1'b0;
        do_reset(2);

        // Full write then read of word 4
        do_req(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 8'h10, 32'h0, 4'h0);
        chk("rd_word4", resp_rdata, 32'hDEADBEEF);

        // Partial write of lane 2 through read-modify-write
        do_req(1'b1, 8'h12, 32'h00AA0000, 4'b0100);
        do_req(1'b0, 8'h10, 32'h0, 4'h0);
        chk("rd_word4_rmw", resp_rdata, 32'hDEAABEEF);

        // Empty mask write leaves word 8 untouched
        do_req(1'b1, 8'h20, 32'hFFFFFFFF, 4'h0);
        do_req(1'b0, 8'h20, 32'h0, 4'h0);

        // Back-to-back reads, second held valid from the start
        exp_q.push_back(exp_mem[63]);
        exp_q.push_back(exp_mem[0]);
        last_rdata = exp_mem[0];
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hFC;
        @(negedge clk);
        chk("b2b_addr_first", 32'(ram_address), 32'h3F);
        chk("b2b_busy", 32'(req_ready), 32'd0);
        req_addr = 8'h00;
        @(negedge clk);
        chk("b2b_resp_first", 32'(resp_valid), 32'd1);
        chk("b2b_ready_in_resp", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("b2b_addr_second", 32'(ram_address), 32'h00);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_resp_second", 32'(resp_valid), 32'd1);

        // More lane patterns at the address extremes
        do_req(1'b1, 8'hFF, 32'h11223344, 4'b1001);
        do_req(1'b0, 8'hFD, 32'h0, 4'h0);
        do_req(1'b1, 8'h01, 32'hCAFEF00D, 4'b0011);
        do_req(1'b0, 8'h00, 32'h0, 4'h0);

        // Reset in the middle of a write pulse
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h14; req_wdata = 32'h12345678; req_bmask = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!ram_is_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_pulse_seen", 32'(ram_is_write), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_we_low", 32'(ram_is_write), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'(READY_RST));
        chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        do_reset(1);
        exp_mem[5] = 32'hx;
        do_req(1'b0, 8'h00, 32'h0, 4'h0);

`ifdef RAM_CTRL_ZERO_INIT_EN
        // Zero-fill sweep clears previously written words
        do_req(1'b1, 8'h00, 32'h01010101, 4'hF);
        do_req(1'b1, 8'h7C, 32'h31313131, 4'hF);
        do_req(1'b1, 8'hFC, 32'h63636363, 4'hF);
        do_reset(1);
        do_req(1'b0, 8'h00, 32'h0, 4'h0);
        do_req(1'b0, 8'h7C, 32'h0, 4'h0);
        do_req(1'b0, 8'hFC, 32'h0, 4'h0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
